// File: rtl/exec_wb_arbiter.sv
// Register-file write-port arbiter: ALU results win the port, FPU results bypass or queue in a
// small FIFO whose entries are squashed when a newer ALU write targets the same register.
module exec_wb_arbiter #(
  parameter int DEPTH = 4,
  parameter int AW    = 6,
  parameter int DW    = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [AW-1:0]          alu_addr,
  input  logic [DW-1:0]          alu_dd_val,
  input  logic [AW-1:0]          fpu_addr,
  input  logic [DW-1:0]          fpu_dd_val,
  output logic                   wb_en,
  output logic [AW-1:0]          wb_addr,
  output logic [DW-1:0]          wb_val,
  output logic [6:0]             is_busy,
  output logic [$clog2(DEPTH):0] fifo_cnt,
  output logic                   ovf
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  // Valid semantics: a stream presents a result in any cycle its address is non-zero; there is
  // no ready back-pressure, the scheduler is throttled through is_busy instead.
  logic [AW-1:0]    addr_q [DEPTH];
  logic [DW-1:0]    val_q  [DEPTH];
  logic [DEPTH-1:0] vld_q, vld_d;
  logic [PW-1:0]    rd_ptr_q, wr_ptr_q;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             wb_en_q, wb_en_d;
  logic [AW-1:0]    wb_addr_q, wb_addr_d;
  logic [DW-1:0]    wb_val_q, wb_val_d;
  logic [6:0]       is_busy_q, is_busy_d;
  logic             ovf_q, ovf_d;

  logic alu_v, fpu_v, empty, full, push, pop;

  assign alu_v = (alu_addr != '0);
  assign fpu_v = (fpu_addr != '0);
  assign empty = (cnt_q == '0);
  assign full  = (cnt_q == CW'(DEPTH));

  always_comb begin
    push      = 1'b0;
    pop       = 1'b0;
    ovf_d     = ovf_q;
    wb_en_d   = 1'b0;
    wb_addr_d = '0;
    wb_val_d  = '0;
    vld_d     = vld_q;
    if (alu_v) begin
      wb_en_d   = 1'b1;
      wb_addr_d = alu_addr;
      wb_val_d  = alu_dd_val;
      // Queued FPU results for this register are older than the ALU write: kill them.
      for (int i = 0; i < DEPTH; i++) begin
        if (addr_q[i] == alu_addr) vld_d[i] = 1'b0;
      end
      if (fpu_v && (fpu_addr != alu_addr)) begin
        if (full) ovf_d = 1'b1;
        else      push  = 1'b1;
      end
    end else if (!empty) begin
      pop = 1'b1;
      if (vld_q[rd_ptr_q]) begin
        wb_en_d   = 1'b1;
        wb_addr_d = addr_q[rd_ptr_q];
        wb_val_d  = val_q[rd_ptr_q];
      end
      push = fpu_v;
    end else if (fpu_v) begin
      wb_en_d   = 1'b1;
      wb_addr_d = fpu_addr;
      wb_val_d  = fpu_dd_val;
    end
    if (pop)  vld_d[rd_ptr_q] = 1'b0;
    if (push) vld_d[wr_ptr_q] = 1'b1;
    cnt_d     = cnt_q + CW'(push) - CW'(pop);
    // Stall one entry early so a result already in flight still finds a free slot.
    is_busy_d = (cnt_d >= CW'(DEPTH - 1)) ? 7'h7F : 7'h00;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q     <= '0;
      rd_ptr_q  <= '0;
      wr_ptr_q  <= '0;
      cnt_q     <= '0;
      wb_en_q   <= 1'b0;
      wb_addr_q <= '0;
      wb_val_q  <= '0;
      is_busy_q <= '0;
      ovf_q     <= 1'b0;
    end else begin
      vld_q     <= vld_d;
      rd_ptr_q  <= rd_ptr_q + PW'(pop);
      wr_ptr_q  <= wr_ptr_q + PW'(push);
      cnt_q     <= cnt_d;
      wb_en_q   <= wb_en_d;
      wb_addr_q <= wb_addr_d;
      wb_val_q  <= wb_val_d;
      is_busy_q <= is_busy_d;
      ovf_q     <= ovf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      addr_q[wr_ptr_q] <= fpu_addr;
      val_q[wr_ptr_q]  <= fpu_dd_val;
    end
  end

  assign wb_en    = wb_en_q;
  assign wb_addr  = wb_addr_q;
  assign wb_val   = wb_val_q;
  assign is_busy  = is_busy_q;
  assign fifo_cnt = cnt_q;
  assign ovf      = ovf_q;

endmodule

// File: tb/tb_exec_wb_arbiter.sv
// Bench for exec_wb_arbiter: directed vector table with hand-derived occupancy/stall/overflow
// values, a queue-based write-back reference feeding an expected queue, then a random phase.
module tb_exec_wb_arbiter;
  localparam int DEPTH = 4;
  localparam int AW    = 6;
  localparam int DW    = 32;
  localparam int W     = 1 + AW + DW;

  logic                   clk = 1'b0;
  logic                   rst = 1'b1;
  logic [AW-1:0]          alu_addr = '0, fpu_addr = '0;
  logic [DW-1:0]          alu_dd_val = '0, fpu_dd_val = '0;
  logic                   wb_en;
  logic [AW-1:0]          wb_addr;
  logic [DW-1:0]          wb_val;
  logic [6:0]             is_busy;
  logic [$clog2(DEPTH):0] fifo_cnt;
  logic                   ovf;

  exec_wb_arbiter #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
    .clk(clk), .rst(rst),
    .alu_addr(alu_addr), .alu_dd_val(alu_dd_val),
    .fpu_addr(fpu_addr), .fpu_dd_val(fpu_dd_val),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_val(wb_val),
    .is_busy(is_busy), .fifo_cnt(fifo_cnt), .ovf(ovf)
  );

  // Clock / reset
  always #5 clk = ~clk;

  // Scoreboard
  typedef struct { logic [AW-1:0] addr; logic [DW-1:0] val; logic vld; } ent_t;
  ent_t           fq[$];
  logic [W-1:0]   exp_q[$];
  logic           m_ovf;
  int             checks = 0;
  int             errors = 0;

  typedef struct {
    logic r; logic [AW-1:0] aa; logic [DW-1:0] av; logic [AW-1:0] fa; logic [DW-1:0] fv;
    int ecnt; logic ebusy; logic eovf;
  } vec_t;
  vec_t tbl[$];

  function automatic void add(logic r, logic [AW-1:0] aa, logic [DW-1:0] av,
                              logic [AW-1:0] fa, logic [DW-1:0] fv, int ecnt, logic ebusy, logic eovf);
    vec_t v;
    v.r = r; v.aa = aa; v.av = av; v.fa = fa; v.fv = fv;
    v.ecnt = ecnt; v.ebusy = ebusy; v.eovf = eovf;
    tbl.push_back(v);
  endfunction

  function automatic void chk(string nm, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", nm, act, exp, $time);
    end
  endfunction

  // Reference: ordered list of queued FPU results, squashed by later ALU writes.
  function automatic void model(logic r, logic [AW-1:0] aa, logic [DW-1:0] av,
                                logic [AW-1:0] fa, logic [DW-1:0] fv);
    ent_t e;
    if (r) begin
      fq.delete(); m_ovf = 1'b0; exp_q.push_back('0);
    end else if (aa != 0) begin
      exp_q.push_back({1'b1, aa, av});
      foreach (fq[i]) if (fq[i].addr == aa) fq[i].vld = 1'b0;
      if (fa != 0 && fa != aa) begin
        if (fq.size() >= DEPTH) m_ovf = 1'b1;
        else begin e.addr = fa; e.val = fv; e.vld = 1'b1; fq.push_back(e); end
      end
    end else if (fq.size() > 0) begin
      e = fq.pop_front();
      exp_q.push_back(e.vld ? {1'b1, e.addr, e.val} : '0);
      if (fa != 0) begin e.addr = fa; e.val = fv; e.vld = 1'b1; fq.push_back(e); end
    end else if (fa != 0) begin
      exp_q.push_back({1'b1, fa, fv});
    end else begin
      exp_q.push_back('0);
    end
  endfunction

  // Driver: one cycle of stimulus, then the write-back comparison against the expected queue.
  task automatic drive(input logic r, input logic [AW-1:0] aa, input logic [DW-1:0] av,
                       input logic [AW-1:0] fa, input logic [DW-1:0] fv);
    logic [W-1:0] e;
    @(negedge clk);
    rst = r; alu_addr = aa; alu_dd_val = av; fpu_addr = fa; fpu_dd_val = fv;
    model(r, aa, av, fa, fv);
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      chk("exp_q_empty", 64'd1, 64'd0);
    end else begin
      e = exp_q.pop_front();
      chk("wb_en",   64'(wb_en),   64'(e[W-1]));
      chk("wb_addr", 64'(wb_addr), 64'(e[W-2 -: AW]));
      chk("wb_val",  64'(wb_val),  64'(e[DW-1:0]));
    end
  endtask

  initial begin
    logic [AW-1:0] ra, rf;
    m_ovf = 1'b0;
    // r    aa  av           fa  fv            cnt busy ovf
    add(1, 0,  0,           0,  0,            0, 0, 0);
    for (int i = 0; i < 5; i++) add(0, 0, 0, 0, 0, 0, 0, 0);
    add(0, 0,  0,           5,  32'h3F800000, 0, 0, 0);   // bypass
    add(0, 0,  0,           0,  0,            0, 0, 0);
    add(0, 3,  32'h11,      7,  32'h22,       1, 0, 0);   // collision
    add(0, 0,  0,           0,  0,            0, 0, 0);
    add(0, 0,  0,           0,  0,            0, 0, 0);
    add(0, 1,  32'h01,      9,  32'h99,       1, 0, 0);   // squash
    add(0, 9,  32'hAA,      0,  0,            1, 0, 0);
    add(0, 0,  0,           0,  0,            0, 0, 0);
    add(0, 0,  0,           0,  0,            0, 0, 0);
    add(0, 6,  32'h66,      6,  32'h77,       0, 0, 0);   // same-address conflict
    add(0, 0,  0,           0,  0,            0, 0, 0);
    add(0, 1,  32'h101,     10, 32'h200,      1, 0, 0);   // fill
    add(0, 2,  32'h102,     11, 32'h201,      2, 0, 0);
    add(0, 3,  32'h103,     12, 32'h202,      3, 1, 0);
    add(0, 4,  32'h104,     13, 32'h203,      4, 1, 0);
    add(0, 5,  32'h105,     14, 32'h204,      4, 1, 1);   // overflow drop
    add(0, 0,  0,           0,  0,            3, 1, 1);   // drain
    add(0, 0,  0,           0,  0,            2, 0, 1);
    add(0, 0,  0,           0,  0,            1, 0, 1);
    add(0, 0,  0,           0,  0,            0, 0, 1);
    add(1, 0,  0,           0,  0,            0, 0, 0);   // reset clears ovf
    add(0, 1,  32'h5,       30, 32'h300,      1, 0, 0);   // push+pop, link address
    add(0, 0,  0,           31, 32'h301,      1, 0, 0);
    add(0, 0,  0,           32, 32'h302,      1, 0, 0);
    add(0, 0,  0,           0,  0,            0, 0, 0);
    add(0, 2,  32'h6,       20, 32'h400,      1, 0, 0);   // reset mid-operation
    add(0, 3,  32'h7,       21, 32'h401,      2, 0, 0);
    add(1, 0,  0,           0,  0,            0, 0, 0);
    add(0, 0,  0,           0,  0,            0, 0, 0);
    add(0, 0,  0,           0,  0,            0, 0, 0);

    foreach (tbl[i]) begin
      drive(tbl[i].r, tbl[i].aa, tbl[i].av, tbl[i].fa, tbl[i].fv);
      chk($sformatf("fifo_cnt[%0d]", i), 64'(fifo_cnt), 64'(tbl[i].ecnt));
      chk($sformatf("is_busy[%0d]", i),  64'(is_busy),  tbl[i].ebusy ? 64'h7F : 64'h0);
      chk($sformatf("ovf[%0d]", i),      64'(ovf),      64'(tbl[i].eovf));
      chk($sformatf("no_stale9[%0d]", i), 64'(wb_en && wb_addr == 6'd9 && wb_val == 32'h99), 64'd0);
    end

    // Random traffic on a small address set to exercise squash, wrap and full-FIFO pops.
    for (int n = 0; n < 200; n++) begin
      ra = ($urandom_range(0, 9) < 4) ? AW'($urandom_range(1, 7)) : '0;
      rf = ($urandom_range(0, 9) < 6) ? AW'($urandom_range(1, 7)) : '0;
      drive(1'b0, ra, DW'($urandom), rf, DW'($urandom));
      chk("rnd_cnt",  64'(fifo_cnt), 64'(fq.size()));
      chk("rnd_busy", 64'(is_busy),  (fq.size() >= DEPTH - 1) ? 64'h7F : 64'h0);
      chk("rnd_ovf",  64'(ovf),      64'(m_ovf));
    end
    drive(1'b1, 0, 0, 0, 0);
    chk("final_cnt", 64'(fifo_cnt), 64'd0);
    chk("final_ovf", 64'(ovf), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/exec_wb_arbiter.md
Name: exec_wb_arbiter

Overview:
- Shares the single register-file write port between the execution unit's two result streams.
- ALU/link results arrive as alu_addr/alu_dd_val and carry no buffering.
- FPU results arrive as fpu_addr/fpu_dd_val and are queued in a small FIFO when the port is taken.
- Drives the 7-bit issue-stall mask (is_busy) back to the scheduler and guarantees in-order write semantics per destination register.

Parameters:
DEPTH, 4, FPU result FIFO entries (power of 2, >=2)
AW, 6, destination register address width
DW, 32, result data width

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
alu_addr  in  AW  ALU destination; 0 = no write this cycle
alu_dd_val  in  DW  ALU result
fpu_addr  in  AW  FPU destination; 0 = no write this cycle
fpu_dd_val  in  DW  FPU result
wb_en  out  1  register-file write enable (registered)
wb_addr  out  AW  write address (registered); 0 when wb_en=0
wb_val  out  DW  write data (registered); 0 when wb_en=0
is_busy  out  7  issue stall mask to the scheduler (registered)
fifo_cnt  out  $clog2(DEPTH)+1  current FIFO occupancy
ovf  out  1  sticky overflow error flag

Behaviour:
- Reset (rst=1 at posedge): wb_en=0, wb_addr=0, wb_val=0, is_busy=0, ovf=0, fifo_cnt=0, rd/wr pointers=0, all entry valid bits cleared.
- Reset mid-operation discards queued FPU results; no write is issued for them.
- Input valid definitions: alu_v = (alu_addr != 0); fpu_v = (fpu_addr != 0). Address 31 (link) is treated like any other address.
- Write-port selection, evaluated each cycle; the result is registered onto wb_* at the next posedge, giving 1-cycle latency:
  1. If alu_v: write the ALU result. If fpu_v, push the FPU result.
  2. Else if FIFO non-empty: pop the head. wb_en = head.valid (a squashed entry yields an idle cycle with wb_en=0, wb_addr=0). If fpu_v, push the FPU result.
  3. Else if fpu_v: bypass, writing the FPU result directly without touching the FIFO.
  4. Else: wb_en=0, wb_addr=0, wb_val=0.
- Ordering / squash rule: when alu_v, every FIFO entry with addr == alu_addr has its valid bit cleared in the same cycle. A stale FPU result must never overwrite a newer ALU result.
- Same-cycle conflict: if alu_v && fpu_v && alu_addr == fpu_addr, the FPU result is dropped (not pushed). The ALU result is written.
- Push and pop in the same cycle: occupancy is unchanged and pointers advance independently. Both pointers wrap modulo DEPTH.
- Full FIFO plus a required push:
  - A push is blocked only when no pop occurs that cycle (case 1 with FIFO full).
  - The FPU result is dropped and ovf is set. ovf stays set until rst.
- is_busy is registered:
  - 7'h7F when the next fifo_cnt >= DEPTH-1 (one slot of headroom covers the 1-cycle feedback).
  - 7'h00 otherwise.
- fifo_cnt counts entries including squashed ones.
- No combinational path from inputs to outputs.

Test Plan:
- Reset, then idle inputs for 5 cycles -> wb_en=0, wb_addr=0, is_busy=0, fifo_cnt=0, ovf=0 throughout.
- FPU-only bypass: fpu_addr=5, fpu_dd_val=0x3F800000 for one cycle -> next cycle wb_en=1, wb_addr=5, wb_val=0x3F800000; fifo_cnt stays 0.
- Collision and drain:
  - Cycle 0: alu_addr=3, val=0x11, with fpu_addr=7, val=0x22.
  - Cycle 1: idle.
  - Required: cycle 1 writes 3/0x11, fifo_cnt=1; cycle 2 writes 7/0x22, fifo_cnt=0.
- Squash:
  - Cycle 0: alu=1 with fpu=9 (queued).
  - Cycle 1: alu_addr=9, val=0xAA.
  - Cycle 2: idle.
  - Required: writes 1, then 9/0xAA, then an idle pop cycle with wb_en=0; fifo_cnt returns to 0 and register 9 is never written with the FPU value.
- Fill and stall (DEPTH=4): alu_v and fpu_v both asserted for 3 consecutive cycles -> fifo_cnt 1,2,3; is_busy=7'h7F from the cycle fifo_cnt reaches 3; ovf=0.
- Overflow:
  - Continue alu_v and fpu_v for 2 more cycles.
  - Required: fifo_cnt saturates at 4; the 5th FPU result is dropped; ovf=1 and stays 1.
  - Then idle 4 cycles -> 4 FIFO writes in push order, is_busy falls to 0.
  - Assert rst -> ovf=0.
